// File: rtl/vga_frame_arbiter.sv
// rtl/vga_frame_arbiter.sv - shares one frame SRAM port between camera writes and VGA scan-out prefetch
module vga_frame_arbiter #(
    parameter int FRAME_PIX = 307200,
    parameter int RD_DEPTH  = 16,
    parameter int RD_LOW    = 8
) (
    input  logic        iVGA_CLK,
    input  logic        iRST_n,
    input  logic        iCAM_VALID,
    input  logic        iCAM_SOF,
    input  logic [11:0] iCAM_DATA,
    output logic        oCAM_READY,
    input  logic        iVGA_SOF,
    input  logic        iVGA_REQ,
    output logic [11:0] oVGA_DATA,
    output logic        oUNDERFLOW,
    output logic [18:0] oMEM_ADDR,
    output logic        oMEM_WE,
    output logic [11:0] oMEM_WDATA,
    input  logic [11:0] iMEM_RDATA
);

    localparam int PW = $clog2(RD_DEPTH);
    localparam int CW = PW + 1;
    localparam int LW = CW + 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2
    } state_t;

    state_t        state_q, state_d;

    logic [18:0]   rd_addr_q, rd_addr_d;
    logic [18:0]   wr_addr_q, wr_addr_d;
    logic [18:0]   mem_addr_q, mem_addr_d;
    logic [11:0]   mem_wdata_q, mem_wdata_d;

    // Second stage of the read pipeline: data for this read is on iMEM_RDATA now.
    logic          rd_v2_q;
    logic          rd_v1;

    logic [11:0]   fifo_mem_q [RD_DEPTH];
    logic [PW-1:0] fifo_wp_q, fifo_rp_q;
    logic [CW-1:0] fifo_cnt_q;

    logic [11:0]   vga_data_q;
    logic          underflow_q;

    logic [LW-1:0] rd_level;
    logic          cam_ready;
    logic          cam_fire;
    logic [18:0]   wr_addr_sel;
    logic          fifo_empty;
    logic          push;
    logic          pop;

    function automatic logic [18:0] next_addr(input logic [18:0] a);
        return (a == 19'(FRAME_PIX - 1)) ? 19'd0 : a + 19'd1;
    endfunction

    // Watermark bookkeeping and handshake qualifiers shared by the FSM and the FIFO.
    always_comb begin
        rd_v1       = (state_q == ST_RD);
        rd_level    = LW'(fifo_cnt_q) + LW'(rd_v1) + LW'(rd_v2_q);
        cam_ready   = (rd_level >= LW'(RD_LOW)) & ~iVGA_SOF;
        cam_fire    = iCAM_VALID & cam_ready;
        wr_addr_sel = iCAM_SOF ? 19'd0 : wr_addr_q;
        fifo_empty  = (fifo_cnt_q == '0);
        // A read landing in the SOF cycle belongs to the old frame and is dropped.
        push        = rd_v2_q & ~iVGA_SOF;
        pop         = iVGA_REQ & ~fifo_empty & ~iVGA_SOF;
    end

    // Grant decision and the memory-pin values that go with it.
    always_comb begin
        state_d     = ST_IDLE;
        rd_addr_d   = rd_addr_q;
        wr_addr_d   = wr_addr_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if (iVGA_SOF) begin
            state_d   = ST_IDLE;
            rd_addr_d = 19'd0;
        end else if (rd_level < LW'(RD_LOW)) begin
            state_d = ST_RD;
        end else if (cam_fire) begin
            state_d = ST_WR;
        end else if (rd_level < LW'(RD_DEPTH)) begin
            state_d = ST_RD;
        end
        if (state_d == ST_RD) begin
            mem_addr_d = rd_addr_q;
            rd_addr_d  = next_addr(rd_addr_q);
        end else if (state_d == ST_WR) begin
            mem_addr_d  = wr_addr_sel;
            mem_wdata_d = iCAM_DATA;
            wr_addr_d   = next_addr(wr_addr_sel);
        end
    end

    // Grant state, address counters and registered memory pins; reset drops in-flight reads.
    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n) begin
            state_q     <= ST_IDLE;
            rd_addr_q   <= '0;
            wr_addr_q   <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            rd_v2_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            rd_addr_q   <= rd_addr_d;
            wr_addr_q   <= wr_addr_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            rd_v2_q     <= rd_v1 & ~iVGA_SOF;
        end
    end

    // FIFO pointers and occupancy; SOF empties it for the new frame.
    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n) begin
            fifo_wp_q  <= '0;
            fifo_rp_q  <= '0;
            fifo_cnt_q <= '0;
        end else if (iVGA_SOF) begin
            fifo_wp_q  <= '0;
            fifo_rp_q  <= '0;
            fifo_cnt_q <= '0;
        end else begin
            if (push) fifo_wp_q <= fifo_wp_q + PW'(1);
            if (pop)  fifo_rp_q <= fifo_rp_q + PW'(1);
            case ({push, pop})
                2'b10:   fifo_cnt_q <= fifo_cnt_q + CW'(1);
                2'b01:   fifo_cnt_q <= fifo_cnt_q - CW'(1);
                default: fifo_cnt_q <= fifo_cnt_q;
            endcase
        end
    end

    // FIFO storage; contents are meaningless outside the occupied window so no reset.
    always_ff @(posedge iVGA_CLK) begin
        if (push) fifo_mem_q[fifo_wp_q] <= iMEM_RDATA;
    end

    // Registered pixel output to the VGA controller and the sticky underflow flag.
    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n) begin
            vga_data_q  <= '0;
            underflow_q <= 1'b0;
        end else if (iVGA_SOF) begin
            vga_data_q  <= '0;
            underflow_q <= 1'b0;
        end else if (iVGA_REQ) begin
            if (fifo_empty) begin
                vga_data_q  <= '0;
                underflow_q <= 1'b1;
            end else begin
                vga_data_q  <= fifo_mem_q[fifo_rp_q];
            end
        end else begin
            vga_data_q <= '0;
        end
    end

    assign oCAM_READY = cam_ready;
    assign oVGA_DATA  = vga_data_q;
    assign oUNDERFLOW = underflow_q;
    assign oMEM_ADDR  = mem_addr_q;
    assign oMEM_WE    = (state_q == ST_WR);
    assign oMEM_WDATA = mem_wdata_q;

endmodule

// File: tb/tb_vga_frame_arbiter.sv
// tb/tb_vga_frame_arbiter.sv - directed scoreboard bench for vga_frame_arbiter
module tb_vga_frame_arbiter;

    // Reduced frame so the address wrap is reachable in a short run.
    localparam int FP = 800;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cam_valid, cam_sof;
    logic [11:0] cam_data;
    logic        cam_ready;
    logic        vga_sof, vga_req;
    logic [11:0] vga_data;
    logic        underflow;
    logic [18:0] mem_addr;
    logic        mem_we;
    logic [11:0] mem_wdata;
    logic [11:0] mem_rdata;

    logic [11:0] mem [FP];
    logic        preload;

    int n_vec = 0;
    int n_bad = 0;

    logic [11:0] pix_q [$];
    logic [30:0] wr_q  [$];

    logic [11:0] wr_data_tab [3];
    logic        wr_sof_tab  [3];

    always #5 clk = ~clk;

    vga_frame_arbiter #(.FRAME_PIX(FP), .RD_DEPTH(16), .RD_LOW(8)) dut (
        .iVGA_CLK   (clk),
        .iRST_n     (rst_n),
        .iCAM_VALID (cam_valid),
        .iCAM_SOF   (cam_sof),
        .iCAM_DATA  (cam_data),
        .oCAM_READY (cam_ready),
        .iVGA_SOF   (vga_sof),
        .iVGA_REQ   (vga_req),
        .oVGA_DATA  (vga_data),
        .oUNDERFLOW (underflow),
        .oMEM_ADDR  (mem_addr),
        .oMEM_WE    (mem_we),
        .oMEM_WDATA (mem_wdata),
        .iMEM_RDATA (mem_rdata)
    );

    // Synchronous single-port SRAM: read data valid the cycle after the address.
    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < FP; i++) mem[i] <= i[11:0];
        end else if (mem_we) begin
            mem[mem_addr[9:0]] <= mem_wdata;
        end
        mem_rdata <= mem[mem_addr[9:0]];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        rst_n     = 1'b0;
        cam_valid = 1'b0;
        cam_sof   = 1'b0;
        cam_data  = 12'h000;
        vga_sof   = 1'b0;
        vga_req   = 1'b0;
        preload   = 1'b1;
        wr_data_tab[0] = 12'hABC; wr_sof_tab[0] = 1'b1;
        wr_data_tab[1] = 12'h123; wr_sof_tab[1] = 1'b0;
        wr_data_tab[2] = 12'h456; wr_sof_tab[2] = 1'b0;

        repeat (3) @(negedge clk);
        preload = 1'b0;

        check("rst_vga_data",  32'(vga_data),  32'h0);
        check("rst_underflow", 32'(underflow), 32'h0);
        check("rst_mem_addr",  32'(mem_addr),  32'h0);
        check("rst_mem_we",    32'(mem_we),    32'h0);
        check("rst_mem_wdata", 32'(mem_wdata), 32'h0);
        check("rst_cam_ready", 32'(cam_ready), 32'h0);

        // Idle after reset: prefetch reads 0..15 back to back, then stops.
        rst_n = 1'b1;
        for (int k = 0; k < 16; k++) begin
            step();
            check("prefetch_addr", {12'h0, mem_we, mem_addr}, 32'(k));
        end
        repeat (4) step();
        check("prefetch_stop_addr", {12'h0, mem_we, mem_addr}, 32'd15);
        check("full_cam_ready", 32'(cam_ready), 32'h1);

        // Three camera writes with the FIFO full.
        for (int k = 0; k < 3; k++) begin
            cam_valid = 1'b1;
            cam_sof   = wr_sof_tab[k];
            cam_data  = wr_data_tab[k];
            check("wr_cam_ready", 32'(cam_ready), 32'h1);
            wr_q.push_back({19'(k), wr_data_tab[k]});
            step();
            check("wr_we", 32'(mem_we), 32'h1);
            check("wr_addr_data", 32'({mem_addr, mem_wdata}), 32'(wr_q.pop_front()));
        end
        cam_valid = 1'b0;
        cam_sof   = 1'b0;
        step();
        check("wr_we_off", 32'(mem_we), 32'h0);

        // Pixel = address pattern, then a new frame with a long request burst that wraps.
        preload = 1'b1;
        step();
        preload = 1'b0;
        vga_sof = 1'b1;
        step();
        vga_sof = 1'b0;
        check("sof_cam_ready_low", 32'(cam_ready), 32'h0);
        check("sof_underflow", 32'(underflow), 32'h0);
        repeat (19) step();
        check("lead_cam_ready", 32'(cam_ready), 32'h1);
        vga_req = 1'b1;
        for (int i = 0; i < 840; i++) begin
            pix_q.push_back(12'(i % FP));
            step();
            check("stream_pix", 32'(vga_data), 32'(pix_q.pop_front()));
        end
        vga_req = 1'b0;
        step();
        check("req_low_data", 32'(vga_data), 32'h0);
        check("stream_underflow", 32'(underflow), 32'h0);

        // Request coincident with SOF, then one cycle after it on an empty FIFO.
        vga_sof = 1'b1;
        vga_req = 1'b1;
        step();
        vga_sof = 1'b0;
        check("sof_req_data", 32'(vga_data), 32'h0);
        check("sof_req_underflow", 32'(underflow), 32'h0);
        step();
        check("early_req_data", 32'(vga_data), 32'h0);
        check("early_req_underflow", 32'(underflow), 32'h1);
        vga_req = 1'b0;
        step();
        check("underflow_sticky", 32'(underflow), 32'h1);
        vga_sof = 1'b1;
        step();
        vga_sof = 1'b0;
        check("underflow_cleared", 32'(underflow), 32'h0);

        // Two reads in flight when SOF arrives: their data must not reach the FIFO.
        step();
        step();
        check("inflight_addr", {12'h0, mem_we, mem_addr}, 32'd1);
        vga_sof = 1'b1;
        step();
        vga_sof = 1'b0;
        repeat (20) step();
        vga_req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            pix_q.push_back(12'(i));
            step();
            check("discard_pix", 32'(vga_data), 32'(pix_q.pop_front()));
        end
        vga_req = 1'b0;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
